pc_sbr_sequencer: RTL and testbench



---
 rtl/ev20_pkg.sv | 17 +
 rtl/pc_sbr_sequencer_depth_counter.sv | 33 +++
 rtl/pc_sbr_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sbr_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ev20_pkg.sv
// Shared sizing constants and the resolved command kind for the PC/return-stack sequencer.
package ev20_pkg;

  localparam int PC_W        = 11;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = 3;

  localparam logic [PC_W-1:0] RESET_VECTOR = 11'h000;

  typedef enum logic [1:0] {
    CMD_INC  = 2'd0,
    CMD_JMP  = 2'd1,
    CMD_CALL = 2'd2,
    CMD_RET  = 2'd3
  } cmd_kind_e;

endpackage

// File: rtl/pc_sbr_sequencer_depth_counter.sv
// Saturating up/down occupancy counter for the return stack; inc+dec together is a no-op.
module sbr_depth_counter #(
  parameter int W     = 4,
  parameter int MAX_V = 8
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX_V);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == MAX_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_sbr_sequencer.sv
// Program counter with an 8-entry hardware return stack feeding the ALU stage.
module pc_sbr_sequencer
  import ev20_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_jump,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc_out,
  output logic [15:0]     o_sbr_pc_out,
  output logic            o_sbr_valid,
  output logic [SP_W:0]   o_depth,
  output logic            o_stack_full,
  output logic            o_stack_empty,
  output logic            o_overflow_err,
  output logic            o_underflow_err
);

  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic            r_sbr_valid;
  logic            r_overflow_err;
  logic            r_underflow_err;

  cmd_kind_e       w_cmd;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic [SP_W-1:0] w_sp_top;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_call_full;
  logic            w_ret_empty;

  always_comb begin
    w_cmd = CMD_INC;
    if (i_ret)       w_cmd = CMD_RET;
    else if (i_call) w_cmd = CMD_CALL;
    else if (i_jump) w_cmd = CMD_JMP;
  end

  assign w_pc_inc    = r_pc + 1'b1;
  assign w_sp_top    = r_sp - 1'b1;
  assign w_push      = i_enable && (w_cmd == CMD_CALL) && !w_full;
  assign w_pop       = i_enable && (w_cmd == CMD_RET) && !w_empty;
  assign w_call_full = i_enable && (w_cmd == CMD_CALL) && w_full;
  assign w_ret_empty = i_enable && (w_cmd == CMD_RET) && w_empty;

  // Rejected call/return falls through to a plain increment.
  always_comb begin
    w_pc_next = r_pc;
    if (i_enable) begin
      unique case (w_cmd)
        CMD_JMP:  w_pc_next = i_target;
        CMD_CALL: w_pc_next = w_push ? i_target : w_pc_inc;
        CMD_RET:  w_pc_next = w_pop ? r_stack[w_sp_top] : w_pc_inc;
        default:  w_pc_next = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc            <= RESET_VECTOR;
      r_sp            <= '0;
      r_sbr_valid     <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_sbr_valid <= w_push || w_pop;
      if (w_push)      r_sp <= r_sp + 1'b1;
      else if (w_pop)  r_sp <= w_sp_top;
      if (w_call_full) r_overflow_err  <= 1'b1;
      if (w_ret_empty) r_underflow_err <= 1'b1;
    end
  end

  // Stack storage is deliberately left uninitialised by reset.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_reset) begin
      r_stack[r_sp] <= w_pc_inc;
    end
  end

  sbr_depth_counter #(
    .W     (SP_W + 1),
    .MAX_V (STACK_DEPTH)
  ) u_depth (
    .i_clk   (i_clock),
    .i_srst  (i_reset),
    .i_inc   (w_push),
    .i_dec   (w_pop),
    .o_count (o_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_pc_out        = r_pc;
  assign o_sbr_pc_out    = {{(16 - PC_W){1'b0}}, r_pc};
  assign o_sbr_valid     = r_sbr_valid;
  assign o_stack_full    = w_full;
  assign o_stack_empty   = w_empty;
  assign o_overflow_err  = r_overflow_err;
  assign o_underflow_err = r_underflow_err;

endmodule

// File: tb/tb_pc_sbr_sequencer.sv
// Directed scoreboard bench for pc_sbr_sequencer: driver queues hand-computed results, monitor checks them.
module tb_pc_sbr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        jmp = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [10:0] tgt = '0;

  logic [10:0] pc_out;
  logic [15:0] sbr_pc_out;
  logic        sbr_valid;
  logic [3:0]  depth;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [10:0] pc;
    logic [3:0]  depth;
    logic        valid;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   step_no = 0;

  always #5 clk = ~clk;

  pc_sbr_sequencer dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_jump          (jmp),
    .i_call          (call),
    .i_ret           (ret),
    .i_target        (tgt),
    .o_pc_out        (pc_out),
    .o_sbr_pc_out    (sbr_pc_out),
    .o_sbr_valid     (sbr_valid),
    .o_depth         (depth),
    .o_stack_full    (full),
    .o_stack_empty   (empty),
    .o_overflow_err  (ovf),
    .o_underflow_err (unf)
  );

  task automatic step(input logic s_rst, input logic s_en, input logic s_jmp,
                      input logic s_call, input logic s_ret, input logic [10:0] s_tgt,
                      input logic [10:0] e_pc, input logic [3:0] e_depth,
                      input logic e_valid, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    rst  = s_rst;
    en   = s_en;
    jmp  = s_jmp;
    call = s_call;
    ret  = s_ret;
    tgt  = s_tgt;
    e.idx   = step_no;
    e.pc    = e_pc;
    e.depth = e_depth;
    e.valid = e_valid;
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: outputs are stable 2 time units after the edge that consumed the queued step.
  initial begin
    exp_t e;
    logic [15:0] e_sbr;
    logic        e_full;
    logic        e_empty;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        e_sbr   = {5'b0, e.pc};
        e_full  = (e.depth == 4'd8);
        e_empty = (e.depth == 4'd0);
        checks++;
        if (pc_out !== e.pc || sbr_pc_out !== e_sbr || depth !== e.depth ||
            sbr_valid !== e.valid || ovf !== e.ovf || unf !== e.unf ||
            full !== e_full || empty !== e_empty) begin
          errors++;
          $display("FAIL step%0d: got pc=%h sbr=%h depth=%0d valid=%b full=%b empty=%b ovf=%b unf=%b, required pc=%h sbr=%h depth=%0d valid=%b full=%b empty=%b ovf=%b unf=%b",
                   e.idx, pc_out, sbr_pc_out, depth, sbr_valid, full, empty, ovf, unf,
                   e.pc, e_sbr, e.depth, e.valid, e_full, e_empty, e.ovf, e.unf);
        end else begin
          $display("ok   step%0d: pc=%h depth=%0d valid=%b ovf=%b unf=%b",
                   e.idx, pc_out, depth, sbr_valid, ovf, unf);
        end
      end
    end
  end

  initial begin
    // rst en jmp call ret tgt | pc depth valid ovf unf
    step(1, 0, 0, 0, 0, 11'h000, 11'h000, 4'd0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      step(0, 1, 0, 0, 0, 11'h000, 11'(k), 4'd0, 0, 0, 0);

    // Single call/return round trip
    step(0, 1, 1, 0, 0, 11'h010, 11'h010, 4'd0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 11'h200, 11'h200, 4'd1, 1, 0, 0);
    step(0, 1, 0, 0, 1, 11'h000, 11'h011, 4'd0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 11'h000, 11'h012, 4'd0, 0, 0, 0);

    // Fill the stack, overflow once, then unwind LIFO
    step(0, 1, 1, 0, 0, 11'h0FF, 11'h0FF, 4'd0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      step(0, 1, 0, 1, 0, 11'(11'h100 + k), 11'(11'h100 + k), 4'(k + 1), 1, 0, 0);
    step(0, 1, 0, 1, 0, 11'h108, 11'h108, 4'd8, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      step(0, 1, 0, 0, 1, 11'h000, 11'(11'h107 - k), 4'(7 - k), 1, 1, 0);

    // Underflow at 0x7FF wraps PC and sets the sticky flag
    step(1, 0, 0, 0, 0, 11'h000, 11'h000, 4'd0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 11'h7FF, 11'h7FF, 4'd0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 11'h000, 11'h000, 4'd0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 11'h000, 11'h001, 4'd0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 11'h000, 11'h001, 4'd0, 0, 0, 1);

    // Call+Ret+Jump together: Ret wins, no flags; Enable=0 holds everything
    step(1, 0, 0, 0, 0, 11'h000, 11'h000, 4'd0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 11'h000, 11'h001, 4'd0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 11'h050, 11'h050, 4'd1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 11'h300, 11'h002, 4'd0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 11'h123, 11'h002, 4'd0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 11'h123, 11'h002, 4'd0, 0, 0, 0);

    // Reset overrides a call issued at depth 3
    step(0, 1, 0, 1, 0, 11'h010, 11'h010, 4'd1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 11'h020, 11'h020, 4'd2, 1, 0, 0);
    step(0, 1, 0, 1, 0, 11'h030, 11'h030, 4'd3, 1, 0, 0);
    step(1, 1, 0, 1, 0, 11'h040, 11'h000, 4'd0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 11'h000, 11'h001, 4'd0, 0, 0, 1);

    @(negedge clk);
    en   = 1'b0;
    call = 1'b0;
    ret  = 1'b0;
    jmp  = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries still pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
